// File: rtl/event_arbiter.sv
// Event arbiter: captures single-cycle event pulses into per-requester pending
// flags and offers them one at a time to a shared consumer in round-robin order.
// Tracks sticky per-requester overflow for events dropped while already pending.
module event_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] evt_pulse,
  input  logic [NUM_REQ-1:0] evt_mask,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] pend,
  output logic [NUM_REQ-1:0] ovf,
  input  logic [NUM_REQ-1:0] ovf_clr
);

  // Index width with one spare bit so rr_ptr + offset never overflows before wrap.
  localparam int unsigned SUM_W = ID_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nx;
  logic [ID_W-1:0]    out_id_nx;
  logic               out_valid_nx;
  logic [NUM_REQ-1:0] pend_nx, ovf_nx;
  logic [NUM_REQ-1:0] capture, grant_clr;
  logic               xfer;
  logic               sel_found;
  logic [ID_W-1:0]    sel_id;
  logic [SUM_W-1:0]   idx;

  // Round-robin search: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = SUM_W'(rr_ptr) + SUM_W'(k);
      if (idx >= SUM_W'(NUM_REQ)) begin
        idx = idx - SUM_W'(NUM_REQ);
      end
      if (!sel_found && pend[idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[ID_W-1:0];
      end
    end
  end

  // Next-state, pending/overflow update and offer control.
  always_comb begin
    state_nx     = state;
    out_valid_nx = out_valid;
    out_id_nx    = out_id;
    rr_ptr_nx    = rr_ptr;
    xfer         = out_valid & out_ready;
    capture      = evt_pulse & evt_mask;
    grant_clr    = '0;
    if (xfer) begin
      grant_clr[out_id] = 1'b1;
    end
    // A new event in the grant cycle re-arms pend without counting as overflow.
    pend_nx = capture | (pend & ~grant_clr);
    // Set condition has priority over write-1-to-clear.
    ovf_nx  = (capture & pend & ~grant_clr) | (ovf & ~ovf_clr);

    case (state)
      IDLE: begin
        if (sel_found) begin
          out_id_nx    = sel_id;
          out_valid_nx = 1'b1;
          state_nx     = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          rr_ptr_nx    = (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + ID_W'(1);
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      rr_ptr    <= '0;
      pend      <= '0;
      ovf       <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= out_valid_nx;
      out_id    <= out_id_nx;
      rr_ptr    <= rr_ptr_nx;
      pend      <= pend_nx;
      ovf       <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_event_arbiter.sv
// Bench for event_arbiter: directed vector table, hand-written multi-cycle
// sequences (backpressure, async reset) and randomized traffic against a model.
module tb_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  evt_pulse = '0;
  logic [N-1:0]  evt_mask = '1;
  logic          out_valid;
  logic [IW-1:0] out_id;
  logic          out_ready = 1'b0;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;
  logic [N-1:0]  ovf_clr = '0;

  int checks = 0;
  int errors = 0;

  event_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .evt_pulse(evt_pulse), .evt_mask(evt_mask),
    .out_valid(out_valid), .out_id(out_id), .out_ready(out_ready),
    .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs already set, advance past the edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; evt_pulse = '0; evt_mask = '1; out_ready = 1'b0; ovf_clr = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Wait for out_valid within a cycle budget; an expired budget is a failure.
  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, int'(out_valid), 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         r;
    logic [N-1:0] p;
    logic [N-1:0] m;
    logic         rdy;
    logic [N-1:0] c;
    logic         v;
    int           id;
    logic [N-1:0] pe;
    logic [N-1:0] ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] p, input logic [N-1:0] m,
                     input logic rdy, input logic [N-1:0] c, input logic v,
                     input int id, input logic [N-1:0] pe, input logic [N-1:0] ov);
    vec_t e;
    e.r = r; e.p = p; e.m = m; e.rdy = rdy; e.c = c;
    e.v = v; e.id = id; e.pe = pe; e.ov = ov;
    tbl.push_back(e);
  endtask

  // ---------------- reference model ----------------
  bit m_pend[N];
  bit m_ovf[N];
  bit m_valid;
  int m_id;
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_valid = 1'b0; m_id = 0; m_ptr = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit np[N];
    bit no[N];
    bit xfer, ev, g, found;
    xfer = m_valid && out_ready;
    for (int i = 0; i < N; i++) begin
      ev = evt_pulse[i] && evt_mask[i];
      g  = xfer && (m_id == i);
      np[i] = ev || (m_pend[i] && !g);
      no[i] = (ev && m_pend[i] && !g) || (m_ovf[i] && !ovf_clr[i]);
    end
    if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && m_pend[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_id  = (m_ptr + k) % N;
        end
      end
      m_valid = found;
    end else if (xfer) begin
      m_valid = 1'b0;
      m_ptr   = (m_id + 1) % N;
    end
    m_pend = np;
    m_ovf  = no;
  endtask

  function automatic int pack(input bit a[N]);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) if (a[i]) s += (1 << i);
    return s;
  endfunction

  initial begin
    do_reset();

    // Single event latency
    add(1, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    add(0, 4'h4, 4'hF, 1, 4'h0, 0, -1, 4'h4, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  2, 4'h4, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    // Round robin from a fresh reset: grants 0,1,3 then lone 0 after 3
    add(1, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    add(0, 4'hB, 4'hF, 1, 4'h0, 0, -1, 4'hB, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  0, 4'hB, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'hA, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  1, 4'hA, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h8, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  3, 4'h8, 4'h0);
    add(0, 4'h1, 4'hF, 0, 4'h0, 1,  3, 4'h9, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h1, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  0, 4'h1, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    // Overflow on requester 0, clear, then set-beats-clear
    add(0, 4'h1, 4'hF, 0, 4'h0, 0, -1, 4'h1, 4'h0);
    add(0, 4'h1, 4'hF, 0, 4'h0, 1,  0, 4'h1, 4'h1);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h1);
    add(0, 4'h0, 4'hF, 1, 4'h1, 0, -1, 4'h0, 4'h0);
    add(0, 4'h1, 4'hF, 0, 4'h0, 0, -1, 4'h1, 4'h0);
    add(0, 4'h1, 4'hF, 0, 4'h1, 1,  0, 4'h1, 4'h1);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h1);
    add(0, 4'h0, 4'hF, 1, 4'h1, 0, -1, 4'h0, 4'h0);
    // Masked pulse is ignored
    add(0, 4'h1, 4'hE, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    add(0, 4'h0, 4'hE, 1, 4'h0, 0, -1, 4'h0, 4'h0);
    // Pulse colliding with its own transfer re-arms pend without overflow
    add(0, 4'h4, 4'hF, 1, 4'h0, 0, -1, 4'h4, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  2, 4'h4, 4'h0);
    add(0, 4'h4, 4'hF, 1, 4'h0, 0, -1, 4'h4, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 1,  2, 4'h4, 4'h0);
    add(0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 4'h0, 4'h0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; evt_pulse = tbl[i].p; evt_mask = tbl[i].m;
      out_ready = tbl[i].rdy; ovf_clr = tbl[i].c;
      tick();
      chk($sformatf("row%0d_valid", i), int'(out_valid), int'(tbl[i].v));
      chk($sformatf("row%0d_pend", i), int'(pend), int'(tbl[i].pe));
      chk($sformatf("row%0d_ovf", i), int'(ovf), int'(tbl[i].ov));
      if (tbl[i].id >= 0) chk($sformatf("row%0d_id", i), int'(out_id), tbl[i].id);
    end
    rst = 1'b0; evt_pulse = '0; evt_mask = '1; ovf_clr = '0;

    // Backpressure: id 1 held for 5 stalled cycles, pulse on 3 meanwhile
    do_reset();
    evt_pulse = 4'h2;
    tick();
    evt_pulse = 4'h0;
    wait_valid("bp_offer", 5);
    chk("bp_first_id", int'(out_id), 1);
    evt_pulse = 4'h8;
    for (int c = 0; c < 5; c++) begin
      tick();
      evt_pulse = 4'h0;
      chk($sformatf("bp_hold_valid%0d", c), int'(out_valid), 1);
      chk($sformatf("bp_hold_id%0d", c), int'(out_id), 1);
    end
    chk("bp_pend", int'(pend), 4'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", int'(out_valid), 0);
    tick();
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_id", int'(out_id), 3);
    tick();

    // Asynchronous reset during an offer discards everything
    do_reset();
    evt_pulse = 4'h6;
    tick();
    evt_pulse = 4'h0;
    wait_valid("rst_offer", 5);
    chk("rst_pre_pend", int'(pend), 4'h6);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_id", int'(out_id), 0);
    chk("rst_async_pend", int'(pend), 0);
    chk("rst_async_ovf", int'(ovf), 0);
    tick();
    rst = 1'b0;
    evt_pulse = 4'h8;
    tick();
    evt_pulse = 4'h0;
    chk("rst_post_pend", int'(pend), 4'h8);
    tick();
    chk("rst_post_valid", int'(out_valid), 1);
    chk("rst_post_id", int'(out_id), 3);
    out_ready = 1'b1;
    tick();

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) evt_pulse[i] = ($urandom_range(0, 3) == 0);
      evt_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      model_step();
      tick();
      chk($sformatf("rnd%0d_valid", c), int'(out_valid), int'(m_valid));
      chk($sformatf("rnd%0d_pend", c), int'(pend), pack(m_pend));
      chk($sformatf("rnd%0d_ovf", c), int'(ovf), pack(m_ovf));
      if (m_valid) chk($sformatf("rnd%0d_id", c), int'(out_id), m_id);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of event requesters; legal range 2..8.
REQ-002 Parameter: ID_W, 2, width of the granted-requester index; SHALL equal clog2(NUM_REQ).
REQ-003 Port: clk  input  1  single system clock; all state on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: evt_pulse  input  NUM_REQ  single-cycle event pulses, one per requester, already synchronous to clk (edge-synchronized upstream).
REQ-006 Port: evt_mask  input  NUM_REQ  per-requester capture enable; 1 = enabled.
REQ-007 Port: out_valid  output  1  an event is offered to the shared consumer.
REQ-008 Port: out_id  output  ID_W  index of the offered requester.
REQ-009 Port: out_ready  input  1  consumer accepts; transfer = out_valid & out_ready on a clk edge.
REQ-010 Port: pend  output  NUM_REQ  per-requester pending flags (registered).
REQ-011 Port: ovf  output  NUM_REQ  sticky per-requester overflow flags (registered).
REQ-012 Port: ovf_clr  input  NUM_REQ  write-1-to-clear for ovf.

Function
REQ-013 pend[i] SHALL be set on the clk edge after a cycle with evt_pulse[i]=1 and evt_mask[i]=1.
REQ-014 evt_mask SHALL gate capture only; clearing evt_mask[i] SHALL NOT clear an already-set pend[i].
REQ-015 pend[i] SHALL clear on the edge of a transfer with out_id=i, unless a masked-in evt_pulse[i] occurs in that same cycle, in which case pend[i] stays 1 and no overflow is flagged.
REQ-016 ovf[i] SHALL set when a masked-in evt_pulse[i] arrives while pend[i]=1 and pend[i] is not cleared by a transfer that cycle; the event is otherwise dropped (pend stays 1, one event only).
REQ-017 ovf[i] SHALL clear on ovf_clr[i]=1; a simultaneous set condition SHALL win (ovf[i] stays 1).
REQ-018 FSM states: IDLE, OFFER. Reset state IDLE.
REQ-019 IDLE: if any pend bit is 1, select the first set pend bit searching upward from rr_ptr with wrap from NUM_REQ-1 to 0; register out_id, assert out_valid on the next edge, go to OFFER; otherwise stay IDLE with out_valid=0.
REQ-020 OFFER: out_valid=1 and out_id SHALL stay stable until a transfer; on transfer, rr_ptr <= (out_id+1) mod NUM_REQ, out_valid deasserts on that edge, go to IDLE.
REQ-021 rr_ptr SHALL reset to 0.
REQ-022 Latency: evt_pulse at cycle T with FSM idle -> pend at T+1 -> out_valid at T+2.
REQ-023 Throughput: at most one transfer per 2 cycles (mandatory IDLE cycle between offers).
REQ-024 out_ready while out_valid=0 SHALL be ignored.
REQ-025 Events arriving during OFFER SHALL only set pend and SHALL NOT change out_id.

Reset
REQ-026 While rst=1, out_valid, out_id, pend, ovf and rr_ptr SHALL be 0 and the FSM in IDLE, irrespective of clk.
REQ-027 Reset asserted mid-OFFER SHALL discard the offered event and all pending events; the first arbitration after release starts from rr_ptr=0.

Verification
REQ-028 Single event: evt_mask=4'hF, evt_pulse=4'b0100 at T, out_ready=1 -> pend=4'b0100 at T+1; out_valid=1, out_id=2 at T+2; pend=0 and out_valid=0 at T+3.
REQ-029 Round robin: evt_pulse=4'b1011 in one cycle, out_ready=1 -> grants in order 0,1,3, each separated by one idle cycle; the next lone event on 0 is granted after any pending 1..3.
REQ-030 Backpressure: out_ready=0 for 5 cycles during OFFER with id=1 and a new pulse on 3 -> out_id stays 1 throughout; id 3 is granted after the transfer.
REQ-031 Overflow: two masked-in pulses on requester 0 before grant -> ovf=4'b0001 and exactly one transfer with id 0; ovf_clr=4'b0001 -> ovf=0; simultaneous set and clear -> ovf stays 1.
REQ-032 Masking and collision: evt_mask=4'b1110 with pulse on 0 -> no pend and no offer; a pulse on 2 in the same cycle as the transfer of id 2 -> pend[2] stays 1, ovf[2]=0, id 2 offered again.
REQ-033 Reset mid-operation: assert rst asynchronously during OFFER with pend=4'b0110 -> all outputs 0 immediately; after release, an event on 3 is granted with out_id=3.
